// File: rtl/mash_ncn_combiner.sv
// MASH 1-1-1 noise-cancellation combiner: forms y = q1 + (1-z^-1)q2 + (1-z^-1)^2 q3,
// adds it to the integer divide word and delivers a clamped, registered divider ratio.
module mash_ncn_combiner #(
  parameter int unsigned P_INT_WIDTH = 8,
  parameter int unsigned P_MIN_DIV   = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_en,
  input  logic                   i_clr,
  input  logic                   i_quantize1,
  input  logic                   i_quantize2,
  input  logic                   i_quantize3,
  input  logic [P_INT_WIDTH-1:0] i_int_div,
  input  logic                   i_clr_ovf,
  output logic [3:0]             o_offset,
  output logic [P_INT_WIDTH-1:0] o_div_ratio,
  output logic                   o_div_valid,
  output logic                   o_ovf
);

  localparam int unsigned Y_W   = 5;
  localparam int unsigned SUM_W = P_INT_WIDTH + 2;
  localparam int unsigned CNT_W = 2;

  localparam logic signed [SUM_W-1:0] MIN_S = SUM_W'(P_MIN_DIV);
  localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'((2 ** P_INT_WIDTH) - 1);
  localparam logic [CNT_W-1:0]        WARM  = CNT_W'(2);

  logic                    q2_d1;
  logic                    q3_d1;
  logic                    q3_d2;
  logic [CNT_W-1:0]        warm_cnt;

  logic signed [Y_W-1:0]   y_c;
  logic signed [SUM_W-1:0] sum_c;
  logic                    clamp_lo_c;
  logic                    clamp_hi_c;
  logic                    tick_c;

  // Offset and widened sum; modulo-32 arithmetic yields the correct signed y in -3..+4.
  always_comb begin
    y_c = Y_W'(i_quantize1) + Y_W'(i_quantize2) - Y_W'(q2_d1)
        + Y_W'(i_quantize3) - Y_W'({q3_d1, 1'b0}) + Y_W'(q3_d2);
    sum_c = $signed({2'b00, i_int_div}) + $signed({{(SUM_W-Y_W){y_c[Y_W-1]}}, y_c});
    clamp_lo_c = (sum_c < MIN_S);
    clamp_hi_c = (sum_c > MAX_S);
    tick_c     = i_en && !i_clr;
  end

  // History and warm-up tracking; clear outranks the modulator tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      q2_d1    <= 1'b0;
      q3_d1    <= 1'b0;
      q3_d2    <= 1'b0;
      warm_cnt <= '0;
    end else if (i_clr) begin
      q2_d1    <= 1'b0;
      q3_d1    <= 1'b0;
      q3_d2    <= 1'b0;
      warm_cnt <= '0;
    end else if (i_en) begin
      q2_d1 <= i_quantize2;
      q3_d2 <= q3_d1;
      q3_d1 <= i_quantize3;
      if (warm_cnt != WARM) begin
        warm_cnt <= warm_cnt + CNT_W'(1);
      end
    end
  end

  // Registered divider outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_offset    <= '0;
      o_div_ratio <= P_INT_WIDTH'(P_MIN_DIV);
      o_div_valid <= 1'b0;
    end else begin
      o_div_valid <= 1'b0;
      if (tick_c) begin
        o_offset    <= y_c[3:0];
        o_div_valid <= (warm_cnt == WARM);
        if (clamp_lo_c) begin
          o_div_ratio <= P_INT_WIDTH'(P_MIN_DIV);
        end else if (clamp_hi_c) begin
          o_div_ratio <= '1;
        end else begin
          o_div_ratio <= sum_c[P_INT_WIDTH-1:0];
        end
      end
    end
  end

  // Sticky overflow; a clamp on the same edge beats the clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ovf <= 1'b0;
    end else if (tick_c && (clamp_lo_c || clamp_hi_c)) begin
      o_ovf <= 1'b1;
    end else if (i_clr_ovf) begin
      o_ovf <= 1'b0;
    end
  end

endmodule
